iob_axi_master_bridge: RTL and testbench

Converts the native IOb single-transaction memory interface (CPU/DMA side) into AXI4 single-beat master transactions, and drives the AXI4 RAM slave directly downstream. Holds at most one outstanding transaction; write and read are never concurrent. Flags non-OKAY AXI responses in a sticky error bit.

---
 rtl/iob_axi_master_bridge.sv | 230 +++++++++++++++++++++++
 tb/tb_iob_axi_master_bridge.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_axi_master_bridge.sv
// IOb-to-AXI4 master bridge.
// Turns one native IOb request at a time into a single-beat AXI4 write
// (AW + W + B) or read (AR + R). A non-OKAY response sets a sticky error
// flag, which the host clears with err_clr_i.
`timescale 1ns/1ps

module iob_axi_master_bridge #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int STRB_W = DATA_W / 8,
  parameter int ID_W   = 8,
  parameter int LEN_W  = 8,
  parameter int AXI_ID = 0
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  // IOb side
  input  logic              iob_valid_i,
  input  logic [ADDR_W-1:0] iob_addr_i,
  input  logic [DATA_W-1:0] iob_wdata_i,
  input  logic [STRB_W-1:0] iob_wstrb_i,
  output logic              iob_ready_o,
  output logic              iob_rvalid_o,
  output logic [DATA_W-1:0] iob_rdata_o,
  output logic              err_o,
  input  logic              err_clr_i,
  // AXI write address channel
  output logic [ID_W-1:0]   axi_awid_o,
  output logic [ADDR_W-1:0] axi_awaddr_o,
  output logic [LEN_W-1:0]  axi_awlen_o,
  output logic [2:0]        axi_awsize_o,
  output logic [1:0]        axi_awburst_o,
  output logic [1:0]        axi_awlock_o,
  output logic [3:0]        axi_awcache_o,
  output logic [2:0]        axi_awprot_o,
  output logic [3:0]        axi_awqos_o,
  output logic              axi_awvalid_o,
  input  logic              axi_awready_i,
  // AXI write data channel
  output logic [DATA_W-1:0] axi_wdata_o,
  output logic [STRB_W-1:0] axi_wstrb_o,
  output logic              axi_wlast_o,
  output logic              axi_wvalid_o,
  input  logic              axi_wready_i,
  // AXI write response channel
  input  logic [ID_W-1:0]   axi_bid_i,
  input  logic [1:0]        axi_bresp_i,
  input  logic              axi_bvalid_i,
  output logic              axi_bready_o,
  // AXI read address channel
  output logic [ID_W-1:0]   axi_arid_o,
  output logic [ADDR_W-1:0] axi_araddr_o,
  output logic [LEN_W-1:0]  axi_arlen_o,
  output logic [2:0]        axi_arsize_o,
  output logic [1:0]        axi_arburst_o,
  output logic [1:0]        axi_arlock_o,
  output logic [3:0]        axi_arcache_o,
  output logic [2:0]        axi_arprot_o,
  output logic [3:0]        axi_arqos_o,
  output logic              axi_arvalid_o,
  input  logic              axi_arready_i,
  // AXI read data channel
  input  logic [ID_W-1:0]   axi_rid_i,
  input  logic [DATA_W-1:0] axi_rdata_i,
  input  logic [1:0]        axi_rresp_i,
  input  logic              axi_rlast_i,
  input  logic              axi_rvalid_i,
  output logic              axi_rready_o
);

  localparam int                OFF       = $clog2(STRB_W);
  localparam logic [2:0]        AXI_SIZE  = 3'(OFF);
  localparam logic [ADDR_W-1:0] ADDR_MASK = {ADDR_W{1'b1}} << OFF;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WR_RESP,
    RD_ADDR,
    RD_DATA
  } state_t;

  state_t state_q, state_n;

  logic              ready_q, ready_n;
  logic              awvalid_q, awvalid_n;
  logic              wvalid_q, wvalid_n;
  logic              arvalid_q, arvalid_n;
  logic              rvalid_q, rvalid_n;
  logic              err_q, err_n;
  logic              capture;
  logic              rd_load;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic [DATA_W-1:0] rdata_q;

  // Response IDs and rlast are deliberately ignored: only one beat is ever in flight.
  logic unused_resp;
  assign unused_resp = ^{axi_bid_i, axi_rid_i, axi_rlast_i};

  // Control registers: state, handshake flags and the sticky error.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q   <= IDLE;
      ready_q   <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_n;
      ready_q   <= ready_n;
      awvalid_q <= awvalid_n;
      wvalid_q  <= wvalid_n;
      arvalid_q <= arvalid_n;
      rvalid_q  <= rvalid_n;
      err_q     <= err_n;
    end
  end

  // Next-state logic; AW and W retire independently, and an error set beats a clear.
  always_comb begin
    state_n   = state_q;
    awvalid_n = awvalid_q;
    wvalid_n  = wvalid_q;
    arvalid_n = arvalid_q;
    rvalid_n  = 1'b0;
    err_n     = err_q & ~err_clr_i;
    capture   = 1'b0;
    rd_load   = 1'b0;
    case (state_q)
      IDLE: begin
        if (iob_valid_i && ready_q) begin
          capture = 1'b1;
          if (|iob_wstrb_i) begin
            state_n   = WR;
            awvalid_n = 1'b1;
            wvalid_n  = 1'b1;
          end else begin
            state_n   = RD_ADDR;
            arvalid_n = 1'b1;
          end
        end
      end
      WR: begin
        if (axi_awready_i) awvalid_n = 1'b0;
        if (axi_wready_i)  wvalid_n  = 1'b0;
        if (!awvalid_n && !wvalid_n) state_n = WR_RESP;
      end
      WR_RESP: begin
        if (axi_bvalid_i) begin
          if (axi_bresp_i != 2'b00) err_n = 1'b1;
          state_n = IDLE;
        end
      end
      RD_ADDR: begin
        if (axi_arready_i) begin
          arvalid_n = 1'b0;
          state_n   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (axi_rvalid_i) begin
          rd_load  = 1'b1;
          rvalid_n = 1'b1;
          if (axi_rresp_i != 2'b00) err_n = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    ready_n = (state_n == IDLE);
  end

  // Request payload is latched on acceptance; read data on the R handshake.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
    end else begin
      if (capture) begin
        addr_q  <= iob_addr_i & ADDR_MASK;
        wdata_q <= iob_wdata_i;
        wstrb_q <= iob_wstrb_i;
      end
      if (rd_load) rdata_q <= axi_rdata_i;
    end
  end

  assign iob_ready_o   = ready_q;
  assign iob_rvalid_o  = rvalid_q;
  assign iob_rdata_o   = rdata_q;
  assign err_o         = err_q;

  assign axi_awid_o    = ID_W'(AXI_ID);
  assign axi_awaddr_o  = addr_q;
  assign axi_awlen_o   = '0;
  assign axi_awsize_o  = AXI_SIZE;
  assign axi_awburst_o = 2'b01;
  assign axi_awlock_o  = 2'b00;
  assign axi_awcache_o = 4'b0011;
  assign axi_awprot_o  = 3'b000;
  assign axi_awqos_o   = 4'b0000;
  assign axi_awvalid_o = awvalid_q;

  assign axi_wdata_o   = wdata_q;
  assign axi_wstrb_o   = wstrb_q;
  assign axi_wlast_o   = 1'b1;
  assign axi_wvalid_o  = wvalid_q;

  assign axi_bready_o  = (state_q == WR_RESP);

  assign axi_arid_o    = ID_W'(AXI_ID);
  assign axi_araddr_o  = addr_q;
  assign axi_arlen_o   = '0;
  assign axi_arsize_o  = AXI_SIZE;
  assign axi_arburst_o = 2'b01;
  assign axi_arlock_o  = 2'b00;
  assign axi_arcache_o = 4'b0011;
  assign axi_arprot_o  = 3'b000;
  assign axi_arqos_o   = 4'b0000;
  assign axi_arvalid_o = arvalid_q;

  assign axi_rready_o  = (state_q == RD_DATA);

endmodule

// File: tb/tb_iob_axi_master_bridge.sv
// Directed testbench for iob_axi_master_bridge with a small AXI RAM slave model.
`timescale 1ns/1ps

module tb_iob_axi_master_bridge;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;
  localparam int ID_W   = 8;
  localparam int LEN_W  = 8;

  logic              clk_i = 1'b0;
  logic              arst_n_i;
  logic              iob_valid_i;
  logic [ADDR_W-1:0] iob_addr_i;
  logic [DATA_W-1:0] iob_wdata_i;
  logic [STRB_W-1:0] iob_wstrb_i;
  logic              iob_ready_o, iob_rvalid_o, err_o, err_clr_i;
  logic [DATA_W-1:0] iob_rdata_o;

  logic [ID_W-1:0]   axi_awid_o, axi_arid_o, axi_bid_i, axi_rid_i;
  logic [ADDR_W-1:0] axi_awaddr_o, axi_araddr_o;
  logic [LEN_W-1:0]  axi_awlen_o, axi_arlen_o;
  logic [2:0]        axi_awsize_o, axi_arsize_o, axi_awprot_o, axi_arprot_o;
  logic [1:0]        axi_awburst_o, axi_arburst_o, axi_awlock_o, axi_arlock_o;
  logic [3:0]        axi_awcache_o, axi_arcache_o, axi_awqos_o, axi_arqos_o;
  logic              axi_awvalid_o, axi_awready_i, axi_arvalid_o, axi_arready_i;
  logic [DATA_W-1:0] axi_wdata_o, axi_rdata_i;
  logic [STRB_W-1:0] axi_wstrb_o;
  logic              axi_wlast_o, axi_wvalid_o, axi_wready_i;
  logic [1:0]        axi_bresp_i, axi_rresp_i;
  logic              axi_bvalid_i, axi_bready_o, axi_rlast_i, axi_rvalid_i, axi_rready_o;

  int n_compared   = 0;
  int n_mismatched = 0;

  // Slave knobs, written only by the stimulus block
  int         aw_stall_cfg = 0;
  int         r_delay_cfg  = 0;
  logic [1:0] bresp_cfg    = 2'b00;
  logic [1:0] rresp_cfg    = 2'b00;

  always #5 clk_i = ~clk_i;

  iob_axi_master_bridge dut (
    .clk_i(clk_i), .arst_n_i(arst_n_i),
    .iob_valid_i(iob_valid_i), .iob_addr_i(iob_addr_i), .iob_wdata_i(iob_wdata_i),
    .iob_wstrb_i(iob_wstrb_i), .iob_ready_o(iob_ready_o), .iob_rvalid_o(iob_rvalid_o),
    .iob_rdata_o(iob_rdata_o), .err_o(err_o), .err_clr_i(err_clr_i),
    .axi_awid_o(axi_awid_o), .axi_awaddr_o(axi_awaddr_o), .axi_awlen_o(axi_awlen_o),
    .axi_awsize_o(axi_awsize_o), .axi_awburst_o(axi_awburst_o), .axi_awlock_o(axi_awlock_o),
    .axi_awcache_o(axi_awcache_o), .axi_awprot_o(axi_awprot_o), .axi_awqos_o(axi_awqos_o),
    .axi_awvalid_o(axi_awvalid_o), .axi_awready_i(axi_awready_i),
    .axi_wdata_o(axi_wdata_o), .axi_wstrb_o(axi_wstrb_o), .axi_wlast_o(axi_wlast_o),
    .axi_wvalid_o(axi_wvalid_o), .axi_wready_i(axi_wready_i),
    .axi_bid_i(axi_bid_i), .axi_bresp_i(axi_bresp_i), .axi_bvalid_i(axi_bvalid_i),
    .axi_bready_o(axi_bready_o),
    .axi_arid_o(axi_arid_o), .axi_araddr_o(axi_araddr_o), .axi_arlen_o(axi_arlen_o),
    .axi_arsize_o(axi_arsize_o), .axi_arburst_o(axi_arburst_o), .axi_arlock_o(axi_arlock_o),
    .axi_arcache_o(axi_arcache_o), .axi_arprot_o(axi_arprot_o), .axi_arqos_o(axi_arqos_o),
    .axi_arvalid_o(axi_arvalid_o), .axi_arready_i(axi_arready_i),
    .axi_rid_i(axi_rid_i), .axi_rdata_i(axi_rdata_i), .axi_rresp_i(axi_rresp_i),
    .axi_rlast_i(axi_rlast_i), .axi_rvalid_i(axi_rvalid_i), .axi_rready_o(axi_rready_o)
  );

  // ---------------- AXI RAM slave model ----------------
  logic [31:0] mem [0:15];
  int          aw_wait;
  logic        aw_have, w_have, bvalid_r, ar_have, rvalid_r;
  logic [15:0] aw_addr_r, ar_addr_r;
  logic [31:0] w_data_r, rdata_r;
  logic [3:0]  w_strb_r;
  int          r_cnt;

  assign axi_awready_i = (aw_wait >= aw_stall_cfg);
  assign axi_wready_i  = 1'b1;
  assign axi_arready_i = 1'b1;
  assign axi_bvalid_i  = bvalid_r;
  assign axi_bresp_i   = bresp_cfg;
  assign axi_bid_i     = '0;
  assign axi_rvalid_i  = rvalid_r;
  assign axi_rdata_i   = rdata_r;
  assign axi_rresp_i   = rresp_cfg;
  assign axi_rid_i     = '0;
  assign axi_rlast_i   = 1'b1;

  // Slave: collects AW and W in any order, writes with strobes, answers reads after r_delay_cfg cycles.
  always @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      aw_wait <= 0; aw_have <= 1'b0; w_have <= 1'b0; bvalid_r <= 1'b0;
      ar_have <= 1'b0; rvalid_r <= 1'b0; r_cnt <= 0;
      aw_addr_r <= '0; ar_addr_r <= '0; w_data_r <= '0; w_strb_r <= '0; rdata_r <= '0;
    end else begin
      if (axi_awvalid_o && axi_awready_i) begin
        aw_have <= 1'b1; aw_addr_r <= axi_awaddr_o; aw_wait <= 0;
      end else if (axi_awvalid_o) begin
        aw_wait <= aw_wait + 1;
      end
      if (axi_wvalid_o && axi_wready_i) begin
        w_have <= 1'b1; w_data_r <= axi_wdata_o; w_strb_r <= axi_wstrb_o;
      end
      if (aw_have && w_have && !bvalid_r) begin
        for (int b = 0; b < 4; b++)
          if (w_strb_r[b]) mem[aw_addr_r[5:2]][8*b +: 8] <= w_data_r[8*b +: 8];
        aw_have <= 1'b0; w_have <= 1'b0; bvalid_r <= 1'b1;
      end
      if (bvalid_r && axi_bready_o) bvalid_r <= 1'b0;
      if (axi_arvalid_o && axi_arready_i) begin
        ar_have <= 1'b1; ar_addr_r <= axi_araddr_o; r_cnt <= 0;
      end
      if (ar_have && !rvalid_r) begin
        if (r_cnt >= r_delay_cfg) begin
          rvalid_r <= 1'b1; rdata_r <= mem[ar_addr_r[5:2]]; ar_have <= 1'b0;
        end else begin
          r_cnt <= r_cnt + 1;
        end
      end
      if (rvalid_r && axi_rready_o) rvalid_r <= 1'b0;
    end
  end

  // ---------------- Mid-cycle monitor ----------------
  int          aw_stall_cnt = 0, w_high_cnt = 0, b_cnt = 0, pulse_cnt = 0;
  int          ar_out = 0, ar_max = 0;
  logic [31:0] pulse_data [$];

  // Tally handshakes, IOb read pulses and outstanding ARs once per cycle.
  always @(negedge clk_i) begin
    if (axi_awvalid_o && !axi_awready_i) aw_stall_cnt <= aw_stall_cnt + 1;
    if (axi_wvalid_o) w_high_cnt <= w_high_cnt + 1;
    if (axi_bvalid_i && axi_bready_o) b_cnt <= b_cnt + 1;
    if (iob_rvalid_o) begin
      pulse_cnt <= pulse_cnt + 1;
      pulse_data.push_back(iob_rdata_o);
    end
    if (!arst_n_i) begin
      ar_out <= 0;
    end else begin
      ar_out <= ar_out + int'(axi_arvalid_o && axi_arready_i) - int'(axi_rvalid_i && axi_rready_o);
      if (ar_out + int'(axi_arvalid_o && axi_arready_i) > ar_max)
        ar_max <= ar_out + int'(axi_arvalid_o && axi_arready_i);
    end
  end

  // ---------------- Tasks ----------------
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_compared++;
    assert (observed === expected) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic timeoutFail(input string tag);
    n_compared++;
    n_mismatched++;
    $display("[TB] FAIL %s: observed timeout, expected event within cycle budget", tag);
  endtask

  task automatic waitReady(input string tag);
    int n = 0;
    while (!iob_ready_o && n < 60) begin @(negedge clk_i); n++; end
    if (!iob_ready_o) timeoutFail(tag);
  endtask

  // One IOb request from a negedge; checks the first AXI cycle and waits for completion.
  task automatic applyStimulus(input string tag, input logic [15:0] addr, input logic [31:0] wdata,
                               input logic [3:0] wstrb, output logic [31:0] rdata);
    int n;
    logic [15:0] word_addr;
    word_addr = {addr[15:2], 2'b00};
    rdata = '0;
    waitReady({tag, "_ready"});
    iob_valid_i = 1'b1; iob_addr_i = addr; iob_wdata_i = wdata; iob_wstrb_i = wstrb;
    @(posedge clk_i);
    @(negedge clk_i);
    iob_valid_i = 1'b0; iob_wstrb_i = '0;
    checkOutput({tag, "_ready_drop"}, 32'(iob_ready_o), 32'd0);
    if (wstrb != 4'h0) begin
      checkOutput({tag, "_aw_w_valid"}, 32'({axi_awvalid_o, axi_wvalid_o}), 32'h3);
      checkOutput({tag, "_awaddr"}, 32'(axi_awaddr_o), 32'(word_addr));
      checkOutput({tag, "_wstrb"}, 32'(axi_wstrb_o), 32'(wstrb));
      checkOutput({tag, "_wdata"}, axi_wdata_o, wdata);
      n = 0;
      while (!iob_ready_o && n < 60) begin @(negedge clk_i); n++; end
      if (!iob_ready_o) timeoutFail({tag, "_wr_done"});
    end else begin
      checkOutput({tag, "_arvalid"}, 32'(axi_arvalid_o), 32'd1);
      checkOutput({tag, "_araddr"}, 32'(axi_araddr_o), 32'(word_addr));
      n = 0;
      while (!iob_rvalid_o && n < 60) begin @(negedge clk_i); n++; end
      if (!iob_rvalid_o) begin
        timeoutFail({tag, "_rvalid"});
      end else begin
        rdata = iob_rdata_o;
        checkOutput({tag, "_ready_with_pulse"}, 32'(iob_ready_o), 32'd1);
        @(negedge clk_i);
        checkOutput({tag, "_pulse_one_cycle"}, 32'(iob_rvalid_o), 32'd0);
      end
    end
  endtask

  // ---------------- Directed sequence ----------------
  initial begin
    logic [31:0] rd;
    int pre_stall, pre_w, pre_b, pre_pulse, base, n;

    arst_n_i = 1'b0; iob_valid_i = 1'b0; iob_addr_i = '0; iob_wdata_i = '0;
    iob_wstrb_i = '0; err_clr_i = 1'b0;
    repeat (3) @(negedge clk_i);
    checkOutput("reset_outputs",
                32'({iob_ready_o, iob_rvalid_o, err_o, axi_awvalid_o, axi_wvalid_o,
                     axi_bready_o, axi_arvalid_o, axi_rready_o}), 32'd0);
    checkOutput("reset_rdata", iob_rdata_o, 32'd0);
    checkOutput("reset_addr", 32'(axi_awaddr_o), 32'd0);
    arst_n_i = 1'b1;
    #1 checkOutput("ready_before_first_edge", 32'(iob_ready_o), 32'd0);
    @(negedge clk_i);
    checkOutput("ready_after_first_edge", 32'(iob_ready_o), 32'd1);
    checkOutput("aw_constants",
                {axi_awlen_o, axi_awburst_o, axi_awlock_o, axi_awcache_o, axi_awprot_o,
                 axi_awqos_o, axi_awid_o, axi_wlast_o},
                {8'h00, 2'b01, 2'b00, 4'b0011, 3'b000, 4'h0, 8'h00, 1'b1});
    checkOutput("ar_constants",
                {axi_arlen_o, axi_arburst_o, axi_arlock_o, axi_arcache_o, axi_arprot_o,
                 axi_arqos_o, axi_arid_o, 1'b0},
                {8'h00, 2'b01, 2'b00, 4'b0011, 3'b000, 4'h0, 8'h00, 1'b0});
    checkOutput("sizes", 32'({axi_awsize_o, axi_arsize_o}), 32'({3'd2, 3'd2}));

    // Full-word write then readback
    applyStimulus("wr_full", 16'h0010, 32'hDEADBEEF, 4'hF, rd);
    applyStimulus("rd_full", 16'h0010, 32'h0, 4'h0, rd);
    checkOutput("rd_full_data", rd, 32'hDEADBEEF);

    // Unaligned single-byte write, readback merges the byte
    applyStimulus("wr_byte", 16'h0013, 32'h00AB0000, 4'b0100, rd);
    applyStimulus("rd_merge", 16'h0010, 32'h0, 4'h0, rd);
    checkOutput("rd_merge_data", rd, 32'hDEABBEEF);

    // AW backpressure with W accepted immediately
    pre_stall = aw_stall_cnt; pre_w = w_high_cnt; pre_b = b_cnt;
    aw_stall_cfg = 3;
    applyStimulus("wr_bp", 16'h0020, 32'h12345678, 4'hF, rd);
    aw_stall_cfg = 0;
    repeat (3) @(negedge clk_i);
    checkOutput("bp_aw_stall_cycles", 32'(aw_stall_cnt - pre_stall), 32'd3);
    checkOutput("bp_w_high_cycles", 32'(w_high_cnt - pre_w), 32'd1);
    checkOutput("bp_b_count", 32'(b_cnt - pre_b), 32'd1);
    applyStimulus("rd_bp", 16'h0020, 32'h0, 4'h0, rd);
    checkOutput("rd_bp_data", rd, 32'h12345678);

    // Sticky error from SLVERR on B, then clear
    bresp_cfg = 2'b10;
    applyStimulus("wr_err", 16'h0030, 32'h0BAD0BAD, 4'hF, rd);
    bresp_cfg = 2'b00;
    checkOutput("err_set_bresp", 32'(err_o), 32'd1);
    applyStimulus("rd_err_hold", 16'h0030, 32'h0, 4'h0, rd);
    checkOutput("err_sticky", 32'(err_o), 32'd1);
    err_clr_i = 1'b1;
    @(negedge clk_i);
    err_clr_i = 1'b0;
    checkOutput("err_cleared", 32'(err_o), 32'd0);

    // Clear and SLVERR on R in the same cycle: the set wins
    rresp_cfg = 2'b10; r_delay_cfg = 2;
    waitReady("err_race_ready");
    iob_valid_i = 1'b1; iob_addr_i = 16'h0030; iob_wstrb_i = 4'h0;
    @(posedge clk_i); @(negedge clk_i);
    iob_valid_i = 1'b0;
    n = 0;
    while (!(axi_rvalid_i && axi_rready_o) && n < 60) begin @(negedge clk_i); n++; end
    if (!(axi_rvalid_i && axi_rready_o)) timeoutFail("err_race_rhandshake");
    err_clr_i = 1'b1;
    @(negedge clk_i);
    err_clr_i = 1'b0;
    checkOutput("err_set_beats_clr", 32'(err_o), 32'd1);
    checkOutput("err_race_pulse", 32'(iob_rvalid_o), 32'd1);
    checkOutput("err_race_data", iob_rdata_o, 32'h0BAD0BAD);
    rresp_cfg = 2'b00;

    // Reset while waiting in RD_DATA
    r_delay_cfg = 8;
    waitReady("rst_ready");
    iob_valid_i = 1'b1; iob_addr_i = 16'h0010; iob_wstrb_i = 4'h0;
    @(posedge clk_i); @(negedge clk_i);
    iob_valid_i = 1'b0;
    n = 0;
    while (!axi_rready_o && n < 60) begin @(negedge clk_i); n++; end
    if (!axi_rready_o) timeoutFail("rst_reach_rd_data");
    pre_pulse = pulse_cnt;
    arst_n_i = 1'b0;
    #1 checkOutput("rst_valids_drop",
                   32'({axi_awvalid_o, axi_wvalid_o, axi_arvalid_o, axi_rready_o,
                        axi_bready_o, iob_rvalid_o, iob_ready_o}), 32'd0);
    checkOutput("rst_err_clear", 32'(err_o), 32'd0);
    @(negedge clk_i); @(negedge clk_i);
    arst_n_i = 1'b1;
    r_delay_cfg = 0;
    #1 checkOutput("rst_ready_low_before_edge", 32'(iob_ready_o), 32'd0);
    @(negedge clk_i);
    checkOutput("rst_ready_after_edge", 32'(iob_ready_o), 32'd1);
    repeat (12) @(negedge clk_i);
    checkOutput("rst_no_pulse", 32'(pulse_cnt - pre_pulse), 32'd0);

    // Back-to-back reads with iob_valid_i held
    applyStimulus("pre_wr0", 16'h0000, 32'hA0A0A0A0, 4'hF, rd);
    applyStimulus("pre_wr4", 16'h0004, 32'hB1B1B1B1, 4'hF, rd);
    applyStimulus("pre_wr8", 16'h0008, 32'hC2C2C2C2, 4'hF, rd);
    base = pulse_data.size();
    pre_pulse = pulse_cnt;
    waitReady("b2b_ready");
    iob_valid_i = 1'b1; iob_wstrb_i = 4'h0;
    for (int k = 0; k < 3; k++) begin
      iob_addr_i = 16'(4 * k);
      n = 0;
      while (!iob_ready_o && n < 60) begin @(negedge clk_i); n++; end
      if (!iob_ready_o) timeoutFail("b2b_accept");
      @(posedge clk_i); @(negedge clk_i);
    end
    iob_valid_i = 1'b0;
    n = 0;
    while (pulse_data.size() < base + 3 && n < 60) begin @(negedge clk_i); n++; end
    repeat (4) @(negedge clk_i);
    checkOutput("b2b_pulse_count", 32'(pulse_cnt - pre_pulse), 32'd3);
    if (pulse_data.size() >= base + 3) begin
      checkOutput("b2b_data0", pulse_data[base],     32'hA0A0A0A0);
      checkOutput("b2b_data1", pulse_data[base + 1], 32'hB1B1B1B1);
      checkOutput("b2b_data2", pulse_data[base + 2], 32'hC2C2C2C2);
    end else begin
      timeoutFail("b2b_data");
    end
    checkOutput("ar_max_outstanding", 32'(ar_max), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  // Global time bound so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no completion, expected finish before 200us");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
